// File: rtl/ppe_rr_arbiter.sv
// ppe_rr_arbiter
//
// Registered round-robin arbiter built on a programmable priority encoder (PPE)
// search. One grant per cycle under valid/ready flow control; a held grant is
// frozen until the consumer accepts it. A pointer register advances past each
// served requester and can be overwritten by software.
//
// Optional feature macro: PPE_RRA_LOCK_EN
//   When defined, a per-requester `lock` input lets a locked, still-requesting
//   grantee keep ownership across handshakes (burst ownership).
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [WIDTH] level-sensitive request vector
//   lock        in   [WIDTH] per-requester lock (PPE_RRA_LOCK_EN only)
//   ptr_ld      in   load pointer from ptr_val this cycle
//   ptr_val     in   [IW] software pointer value
//   gnt_ready   in   consumer accepts the current grant
//   gnt_vld     out  a grant is held
//   gnt_idx     out  [IW] index of the granted requester
//   gnt_onehot  out  [WIDTH] one-hot grant, zero when gnt_vld is low
//   ptr         out  [IW] current pointer register

module ppe_rr_arbiter #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
`ifdef PPE_RRA_LOCK_EN
    input  logic [WIDTH-1:0] lock,
`endif
    input  logic             ptr_ld,
    input  logic [IW-1:0]    ptr_val,
    input  logic             gnt_ready,
    output logic             gnt_vld,
    output logic [IW-1:0]    gnt_idx,
    output logic [WIDTH-1:0] gnt_onehot,
    output logic [IW-1:0]    ptr
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q;
    logic [IW-1:0]    gnt_idx_q;
    logic [WIDTH-1:0] gnt_onehot_q;
    logic [IW-1:0]    ptr_q;

    logic             hs;
    logic             keep;
    logic [IW-1:0]    inc_idx;
    logic [IW-1:0]    np;
    logic [WIDTH-1:0] re;
    logic             any_lo;
    logic             any_hi;
    logic [IW-1:0]    idx_lo;
    logic [IW-1:0]    idx_hi;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] sel_onehot;

    assign hs = (state_q == StGrant) && gnt_ready;

`ifdef PPE_RRA_LOCK_EN
    // A locked grantee that still requests is re-granted: pointer stays on it
    // and its bit is not masked out of the evaluation vector.
    assign keep = hs && lock[gnt_idx_q] && req[gnt_idx_q];
`else
    assign keep = 1'b0;
`endif

    assign inc_idx = (gnt_idx_q == IW'(WIDTH - 1)) ? '0 : gnt_idx_q + IW'(1);

    always_comb begin
        np = ptr_q;
        if (ptr_ld) begin
            np = ptr_val;
        end else if (keep) begin
            np = gnt_idx_q;
        end else if (hs) begin
            np = inc_idx;
        end
    end

    // The requester being served is excluded in its own handshake cycle.
    assign re = req & ~((hs && !keep) ? gnt_onehot_q : '0);

    // PPE search: lowest set index >= np, else lowest set index overall.
    // A pointer >= WIDTH masks every bit, so the fallback gives pointer-0 behaviour.
    always_comb begin
        any_lo = 1'b0;
        any_hi = 1'b0;
        idx_lo = '0;
        idx_hi = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (re[i] && !any_lo) begin
                any_lo = 1'b1;
                idx_lo = IW'(i);
            end
            if (re[i] && !any_hi && (i >= 32'(np))) begin
                any_hi = 1'b1;
                idx_hi = IW'(i);
            end
        end
    end

    assign sel_idx    = any_hi ? idx_hi : idx_lo;
    assign sel_onehot = {{(WIDTH - 1){1'b0}}, 1'b1} << sel_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            ptr_q        <= '0;
        end else begin
            ptr_q <= np;
            unique case (state_q)
                StIdle: begin
                    if (any_lo) begin
                        gnt_idx_q    <= sel_idx;
                        gnt_onehot_q <= sel_onehot;
                        state_q      <= StGrant;
                    end
                end
                StGrant: begin
                    // Grant is frozen (no retraction) until the consumer accepts it.
                    if (hs) begin
                        if (any_lo) begin
                            gnt_idx_q    <= sel_idx;
                            gnt_onehot_q <= sel_onehot;
                        end else begin
                            gnt_idx_q    <= '0;
                            gnt_onehot_q <= '0;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt_vld    = (state_q == StGrant);
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign ptr        = ptr_q;

endmodule

// File: tb/tb_ppe_rr_arbiter.sv
// Bench for ppe_rr_arbiter: an 8-wide and a 1024-wide instance. Stimulus pushes
// expected {index, pointer} pairs into per-instance queues; monitors pop and
// compare on every accepted grant.

module tb_ppe_rr_arbiter;

    logic        clk;
    logic        rst_n;

    logic [7:0]  req;
    logic        ptr_ld;
    logic [2:0]  ptr_val;
    logic        gnt_ready;
    logic        gnt_vld;
    logic [2:0]  gnt_idx;
    logic [7:0]  gnt_onehot;
    logic [2:0]  ptr;

    logic [1023:0] w_req;
    logic          w_ptr_ld;
    logic [9:0]    w_ptr_val;
    logic          w_ready;
    logic          w_vld;
    logic [9:0]    w_idx;
    logic [1023:0] w_onehot;
    logic [9:0]    w_ptr;

`ifdef PPE_RRA_LOCK_EN
    logic [7:0]    lock;
    logic [1023:0] w_lock;
`endif

    typedef struct {
        int idx;
        int p;
    } exp_t;

    exp_t q8[$];
    exp_t qw[$];

    int n_vec = 0;
    int n_err = 0;

    ppe_rr_arbiter #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
`ifdef PPE_RRA_LOCK_EN
        .lock       (lock),
`endif
        .ptr_ld     (ptr_ld),
        .ptr_val    (ptr_val),
        .gnt_ready  (gnt_ready),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .ptr        (ptr)
    );

    ppe_rr_arbiter #(.WIDTH(1024)) u_dutw (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (w_req),
`ifdef PPE_RRA_LOCK_EN
        .lock       (w_lock),
`endif
        .ptr_ld     (w_ptr_ld),
        .ptr_val    (w_ptr_val),
        .gnt_ready  (w_ready),
        .gnt_vld    (w_vld),
        .gnt_idx    (w_idx),
        .gnt_onehot (w_onehot),
        .ptr        (w_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: a handshake is pending when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && gnt_vld && gnt_ready) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_grant", 64'(gnt_idx), 64'hFFFF);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_idx", 64'(gnt_idx), 64'(e.idx));
                chk("w8_onehot", 64'(gnt_onehot), 64'(1) << e.idx);
                chk("w8_ptr", 64'(ptr), 64'(e.p));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && w_vld && w_ready) begin
            if (qw.size() == 0) begin
                chk("wide_unexpected_grant", 64'(w_idx), 64'hFFFF);
            end else begin
                exp_t e;
                logic oh_ok;
                e = qw.pop_front();
                oh_ok = (w_onehot == ({{1023{1'b0}}, 1'b1} << e.idx));
                chk("wide_idx", 64'(w_idx), 64'(e.idx));
                chk("wide_onehot_ok", 64'(oh_ok), 64'(1));
                chk("wide_ptr", 64'(w_ptr), 64'(e.p));
            end
        end
    end

    task automatic push8(input int idx, input int p);
        exp_t e;
        e.idx = idx;
        e.p   = p;
        q8.push_back(e);
    endtask

    task automatic pushw(input int idx, input int p);
        exp_t e;
        e.idx = idx;
        e.p   = p;
        qw.push_back(e);
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = '0;
        ptr_ld    = 1'b0;
        ptr_val   = '0;
        gnt_ready = 1'b0;
        w_req     = '0;
        w_ptr_ld  = 1'b0;
        w_ptr_val = '0;
        w_ready   = 1'b0;
`ifdef PPE_RRA_LOCK_EN
        lock      = '0;
        w_lock    = '0;
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("rst_vld", 64'(gnt_vld), 64'(0));
        chk("rst_idx", 64'(gnt_idx), 64'(0));
        chk("rst_onehot", 64'(gnt_onehot), 64'(0));
        chk("rst_ptr", 64'(ptr), 64'(0));
        chk("rst_wide_vld", 64'(w_vld), 64'(0));
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Rotation over 0xA4 from pointer 0
        gnt_ready = 1'b1;
        req       = 8'hA4;
        push8(2, 0);
        push8(5, 3);
        push8(7, 6);
        push8(2, 0);
        #1 chk("rot_lat_before", 64'(gnt_vld), 64'(0));
        cyc(1);
        chk("rot_lat_after", 64'(gnt_vld), 64'(1));
        cyc(3);
        req = '0;
        cyc(1);
        chk("rot_end_vld", 64'(gnt_vld), 64'(0));
        chk("rot_end_ptr", 64'(ptr), 64'(3));

        // Backpressure: grant 2 held while req moves to 0x80
        ptr_ld    = 1'b1;
        ptr_val   = 3'd0;
        gnt_ready = 1'b0;
        cyc(1);
        ptr_ld = 1'b0;
        req    = 8'h04;
        cyc(1);
        req = 8'h80;
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", 64'(gnt_vld), 64'(1));
            chk("bp_idx", 64'(gnt_idx), 64'(2));
            chk("bp_onehot", 64'(gnt_onehot), 64'h04);
            chk("bp_ptr", 64'(ptr), 64'(0));
            cyc(1);
        end
        push8(2, 0);
        push8(7, 3);
        gnt_ready = 1'b1;
        cyc(1);
        req = '0;
        cyc(1);
        chk("bp_end_vld", 64'(gnt_vld), 64'(0));
        chk("bp_end_ptr", 64'(ptr), 64'(0));

        // Pointer load to 6 with req 0x41: 6 then wrap fallback to 0
        ptr_ld  = 1'b1;
        ptr_val = 3'd6;
        req     = 8'h41;
        push8(6, 6);
        push8(0, 7);
        cyc(1);
        ptr_ld = 1'b0;
        cyc(1);
        req = '0;
        cyc(1);
        chk("pl_end_vld", 64'(gnt_vld), 64'(0));
        chk("pl_end_ptr", 64'(ptr), 64'(1));

        // Reset mid-grant
        gnt_ready = 1'b0;
        req       = 8'h20;
        cyc(1);
        chk("mr_vld", 64'(gnt_vld), 64'(1));
        chk("mr_idx", 64'(gnt_idx), 64'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_vld", 64'(gnt_vld), 64'(0));
        chk("mr_rst_idx", 64'(gnt_idx), 64'(0));
        chk("mr_rst_onehot", 64'(gnt_onehot), 64'(0));
        chk("mr_rst_ptr", 64'(ptr), 64'(0));
        cyc(1);
        rst_n     = 1'b1;
        gnt_ready = 1'b1;
        push8(5, 0);
        cyc(1);
        req = '0;
        cyc(1);
        chk("mr_end_vld", 64'(gnt_vld), 64'(0));
        chk("mr_end_ptr", 64'(ptr), 64'(6));

        // Lock scenario, req 0x09 starting from pointer 1
        ptr_ld  = 1'b1;
        ptr_val = 3'd1;
        req     = 8'h09;
`ifdef PPE_RRA_LOCK_EN
        lock = 8'h08;
        push8(3, 1);
        push8(3, 3);
        push8(3, 3);
        push8(0, 4);
        push8(3, 1);
        cyc(1);
        ptr_ld = 1'b0;
        cyc(2);
        lock = '0;
        cyc(2);
        req = '0;
        cyc(1);
        chk("lk_end_vld", 64'(gnt_vld), 64'(0));
        chk("lk_end_ptr", 64'(ptr), 64'(4));
`else
        push8(3, 1);
        push8(0, 4);
        push8(3, 1);
        push8(0, 4);
        cyc(1);
        ptr_ld = 1'b0;
        cyc(3);
        req = '0;
        cyc(1);
        chk("lk_end_vld", 64'(gnt_vld), 64'(0));
        chk("lk_end_ptr", 64'(ptr), 64'(1));
`endif

        // Wide: bits 1023 and 0 with pointer 1000
        w_ready       = 1'b1;
        w_ptr_ld      = 1'b1;
        w_ptr_val     = 10'd1000;
        w_req[1023]   = 1'b1;
        w_req[0]      = 1'b1;
        pushw(1023, 1000);
        pushw(0, 0);
        pushw(1023, 1);
        cyc(1);
        w_ptr_ld = 1'b0;
        cyc(2);
        w_req = '0;
        cyc(1);
        chk("wide_end_vld", 64'(w_vld), 64'(0));
        chk("wide_end_ptr", 64'(w_ptr), 64'(0));

        // Drain with a bounded wait, then insist both scoreboards are empty
        for (int k = 0; k < 20 && (q8.size() != 0 || qw.size() != 0); k++) begin
            cyc(1);
        end
        chk("w8_queue_left", 64'(q8.size()), 64'(0));
        chk("wide_queue_left", 64'(qw.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ppe_rr_arbiter.md
# ppe_rr_arbiter

Parametrised, registered round-robin arbiter built around a programmable priority encoder (PPE) search. It issues one grant per cycle under valid/ready flow control and holds the grant stable while the consumer stalls. A pointer register advances past each served requester, and software can overwrite the pointer. It is the sequential successor to the fixed 1024-bit combinational PPE and serves as the arbitration stage in front of shared ports.

## Interface
- `WIDTH`, default 1024: number of requesters; must be ≥ 2, any value allowed.
- `IW`, default `$clog2(WIDTH)`: width of index and pointer; derived, not overridden.
- `clk` input, 1 bit: clock; all state is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, `WIDTH` bits: request vector, level-sensitive.
- `lock` input, `WIDTH` bits: per-requester lock; present only with `PPE_RRA_LOCK_EN`.
- `ptr_ld` input, 1 bit: load the pointer from `ptr_val` this cycle.
- `ptr_val` input, `IW` bits: software pointer value.
- `gnt_ready` input, 1 bit: consumer accepts the current grant.
- `gnt_vld` output, 1 bit: a grant is held.
- `gnt_idx` output, `IW` bits: index of the granted requester.
- `gnt_onehot` output, `WIDTH` bits: one-hot form of the grant; all-zero when `gnt_vld` = 0.
- `ptr` output, `IW` bits: current pointer register.

## Operation
- PPE search(`R`, `P`): return the lowest set index ≥ `P` in `R`. If there is none, return the lowest set index in `R`. `any` = `|R`.
- Handshake `hs` = `gnt_vld & gnt_ready`.
- Next pointer `np`, in priority order:
  - `ptr_ld` → `ptr_val`.
  - else `hs` → (`gnt_idx` + 1) mod `WIDTH`, so `WIDTH-1` wraps to 0.
  - else → `ptr`.
- Evaluation vector `re` = `req & ~(hs ? gnt_onehot : 0)`. The requester being served is excluded in its handshake cycle.
- Two states:
  - IDLE (`gnt_vld` = 0): each cycle, compute search(`re`, `np`). If `any`, register `gnt_idx`/`gnt_onehot` and go to GRANT. Otherwise stay.
  - GRANT (`gnt_vld` = 1): grant outputs are frozen until `hs`, regardless of `req` changes, including withdrawal of the granted bit (no retraction).
    - On `hs` with `any(re)`: load the new grant and stay in GRANT (back-to-back, one grant per cycle).
    - On `hs` with no `any(re)`: go to IDLE and clear the outputs.
- `ptr` <= `np` every cycle.
- `ptr_val` ≥ `WIDTH` (non-power-of-2 `WIDTH`) is stored as-is. The search then masks all bits and falls back to the lowest set index, which is the same result as pointer 0.
- `ptr_ld` in GRANT without `hs` does not alter the held grant. It affects the next evaluation only.

## Timing
- Reset values: `gnt_vld`=0, `gnt_idx`=0, `gnt_onehot`=0, `ptr`=0. Reset asserts immediately and asynchronously, including mid-grant. After release, the first evaluation happens on the first clock edge.
- Latency: `req` asserted at edge N (state IDLE) → `gnt_vld` = 1 after edge N+1.
- Throughput: one grant per cycle with `gnt_ready` held at 1 and requests pending.
- All outputs are registered. There is no combinational path from `req` or `gnt_ready` to any output.

## Configuration
- `PPE_RRA_LOCK_EN` defined:
  - The `lock` port exists.
  - On `hs` with `lock[gnt_idx] & req[gnt_idx]`: `np` = `gnt_idx` (unless `ptr_ld`), and the granted bit is not masked from `re`. The same requester is re-granted on the next cycle, which gives burst ownership.
  - `ptr_ld` still overrides `np`.
- `PPE_RRA_LOCK_EN` undefined: the `lock` port is absent, and behaviour is as described in Operation.

## Test plan
All scenarios use `WIDTH`=8 unless stated otherwise.
- Rotation: `req`=0xA4, `ptr`=0, `gnt_ready`=1 → `gnt_idx` sequence 2, 5, 7, 2; `ptr` sequence 3, 6, 0, 3; `gnt_vld` first high one cycle after `req`.
- Backpressure: grant idx 2 held with `gnt_ready`=0 for 5 cycles while `req` changes to 0x80 → `gnt_idx`=2 and `gnt_onehot`=0x04 stable, `ptr`=0. Then `gnt_ready`=1 → next grant is 7.
- Pointer load: `ptr_ld`=1, `ptr_val`=6, `req`=0x41 in IDLE → grant 6, then 0 (wrap fallback), `ptr`=1.
- Reset mid-operation: `gnt_vld`=1 with `gnt_idx`=5, `rst_n` driven low between edges → all outputs 0 before the next edge. After release, `req`=0x20 → grant 5.
- Lock (with macro): `req`=0x09, `lock`=0x08, `gnt_ready`=1 → grants 3, 3, 3. Drop `lock` → 0, then 3. Without the macro, the same stimulus gives 3, 0, 3, 0.
- Wide: `WIDTH`=1024, `req` bits 1023 and 0, `ptr_val`=1000 loaded → grant 1023, then 0, then 1023.
